spi_fl_read_seq: RTL and testbench

- Upstream command sequencer for spi_master_fl.
- Converts a block-read request (start address, word count, lane mode) into a series of 32-bit flash read commands on the master's controller interface.
- Returns each data_out word on a valid/ready stream.
- Sits between the system-side memory/DMA logic and spi_master_fl; owns command, address and dummy-cycle selection so callers never drive the raw command fields.

---
 rtl/spi_fl_pkg.sv | 25 ++
 rtl/spi_fl_read_seq_if.sv | 31 +++
 rtl/spi_fl_timeout_cnt.sv | 29 ++
 rtl/spi_fl_read_seq.sv | 135 +++++++++++++
 tb/tb_spi_fl_read_seq.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_fl_pkg.sv
// Shared constants for the flash read sequencer: opcodes, command type,
// FSM state encoding and opcode selection.
package spi_fl_pkg;

    localparam logic [7:0] READ_FAST  = 8'h0B;
    localparam logic [7:0] READ_FAST4 = 8'h0C;
    localparam logic [7:0] READ_QO    = 8'h6B;
    localparam logic [7:0] READ_QO4   = 8'h6C;

    localparam logic [2:0] COMMTYPE_READ = 3'b010;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_DATA = 3'd2;
    localparam logic [2:0] ST_OUT       = 3'd3;
    localparam logic [2:0] ST_WAIT_RDY  = 3'd4;

    // Fast-read opcode for the requested lane mode and address width.
    function automatic logic [7:0] read_opcode(input logic quad, input logic four);
        if (quad)
            return four ? READ_QO4 : READ_QO;
        return four ? READ_FAST4 : READ_FAST;
    endfunction

endpackage

// File: rtl/spi_fl_read_seq_if.sv
// Controller-side link between the read sequencer (master) and
// spi_master_fl (slave).
interface spi_fl_read_seq_if;
    logic [7:0]  command;
    logic [31:0] address;
    logic [2:0]  commtype;
    logic [6:0]  ndata_bits;
    logic [3:0]  dummy_cycles;
    logic [9:0]  frame_struct;
    logic [1:0]  xipbit_en;
    logic [1:0]  spimode;
    logic        manualframe_en;
    logic        fourbyteaddr_on;
    logic [31:0] data_in;
    logic        validflag;
    logic [31:0] data_out;
    logic        validflag_out;
    logic        tready;

    modport master (
        output command, address, commtype, ndata_bits, dummy_cycles, frame_struct,
        output xipbit_en, spimode, manualframe_en, fourbyteaddr_on, data_in, validflag,
        input  data_out, validflag_out, tready
    );

    modport slave (
        input  command, address, commtype, ndata_bits, dummy_cycles, frame_struct,
        input  xipbit_en, spimode, manualframe_en, fourbyteaddr_on, data_in, validflag,
        output data_out, validflag_out, tready
    );
endinterface

// File: rtl/spi_fl_timeout_cnt.sv
// Command-to-data watchdog: cleared on command issue, counts while enabled,
// flags the cycle on which the LIMIT-th clock after the load will occur.
module spi_fl_timeout_cnt #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    // Count cycles since load, saturating once the limit is reached.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    // Asserted one count early so the consumer's registered reaction lands
    // exactly LIMIT cycles after the load edge.
    assign expired = (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/spi_fl_read_seq.sv
// Block-read command sequencer: turns (address, word count, lane mode) into
// one flash read command per word for spi_master_fl and streams the words out.
module spi_fl_read_seq
    import spi_fl_pkg::*;
#(
    parameter bit          FOURBYTE  = 1'b1,
    parameter logic [9:0]  FS_SINGLE = 10'h000,
    parameter logic [9:0]  FS_QUAD   = 10'h008,
    parameter logic [3:0]  DUMMY     = 4'd8,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_nwords,
    input  logic        req_quad,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic        err,
    spi_fl_read_seq_if.master fl
);
    // Word alignment plus 3-byte wrap when 4-byte addressing is off.
    localparam logic [31:0] ADDR_MASK = FOURBYTE ? 32'hFFFF_FFFC : 32'h00FF_FFFC;

    logic [2:0]  state;
    logic [7:0]  count;
    logic [7:0]  command_q;
    logic [31:0] address_q;
    logic [9:0]  fs_q;
    logic        validflag_q;
    logic        tmo_load;
    logic        tmo_expired;

    assign tmo_load = (state == ST_ISSUE) && fl.tready;

    spi_fl_timeout_cnt #(.LIMIT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .load    (tmo_load),
        .en      (state == ST_WAIT_DATA),
        .expired (tmo_expired)
    );

    // Sequencer FSM: accept request, issue one command per word, return words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b1;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            validflag_q <= 1'b0;
            command_q   <= '0;
            address_q   <= '0;
            fs_q        <= FS_SINGLE;
            count       <= '0;
        end else begin
            done        <= 1'b0;
            validflag_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        address_q <= req_addr & ADDR_MASK;
                        count     <= req_nwords;
                        command_q <= read_opcode(req_quad, FOURBYTE);
                        fs_q      <= req_quad ? FS_QUAD : FS_SINGLE;
                        err       <= 1'b0;
                        if (req_nwords == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            req_ready <= 1'b0;
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (fl.tready) begin
                        validflag_q <= 1'b1;
                        state       <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (fl.validflag_out) begin
                        rd_data  <= fl.data_out;
                        rd_valid <= 1'b1;
                        state    <= ST_OUT;
                    end else if (tmo_expired) begin
                        err       <= 1'b1;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (rd_ready) begin
                        rd_valid  <= 1'b0;
                        address_q <= (address_q + 32'd4) & ADDR_MASK;
                        count     <= count - 8'd1;
                        if (count == 8'd1) begin
                            done      <= 1'b1;
                            req_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT_RDY;
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (fl.tready)
                        state <= ST_ISSUE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Command fields toward the master; the fixed ones never change.
    assign fl.command         = command_q;
    assign fl.address         = address_q;
    assign fl.frame_struct    = fs_q;
    assign fl.validflag       = validflag_q;
    assign fl.commtype        = COMMTYPE_READ;
    assign fl.ndata_bits      = 7'd32;
    assign fl.dummy_cycles    = DUMMY;
    assign fl.xipbit_en       = 2'b00;
    assign fl.spimode         = 2'b00;
    assign fl.manualframe_en  = 1'b0;
    assign fl.fourbyteaddr_on = FOURBYTE;
    assign fl.data_in         = '0;
endmodule

// File: tb/tb_spi_fl_read_seq.sv
// Bench for spi_fl_read_seq: two instances (4-byte and 3-byte addressing)
// share one flash-master model; expectations come from a word-list model.
module tb_spi_fl_read_seq;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid0, req_valid1, req_ready0, req_ready1;
    logic [31:0] req_addr;
    logic [7:0]  req_nwords;
    logic        req_quad;
    logic        rd_ready;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1, done0, done1, err0, err1;

    logic        tready, vfo, act;
    logic [31:0] fdata;

    spi_fl_read_seq_if fl0 ();
    spi_fl_read_seq_if fl1 ();

    assign fl0.tready        = tready;
    assign fl1.tready        = tready;
    assign fl0.data_out      = fdata;
    assign fl1.data_out      = fdata;
    assign fl0.validflag_out = vfo & ~act;
    assign fl1.validflag_out = vfo & act;

    spi_fl_read_seq #(.FOURBYTE(1'b1), .TIMEOUT(TO)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .req_nwords(req_nwords), .req_quad(req_quad),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready),
        .done(done0), .err(err0), .fl(fl0)
    );

    spi_fl_read_seq #(.FOURBYTE(1'b0), .TIMEOUT(TO)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr), .req_nwords(req_nwords), .req_quad(req_quad),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready),
        .done(done1), .err(err1), .fl(fl1)
    );

    // Cycle counter and pulse-length monitors
    int unsigned cyc = 0;
    int unsigned vf_cyc0 = 0, vf_cyc1 = 0, dn_cyc0 = 0, dn_cyc1 = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fl0.validflag) vf_cyc0++;
        if (fl1.validflag) vf_cyc1++;
        if (done0) dn_cyc0++;
        if (done1) dn_cyc1++;
    end

    // View of the instance under test
    logic        sel = 1'b0;
    logic        c_rr, c_rdv, c_done, c_err;
    logic [31:0] c_rdd;
    int unsigned c_vfc, c_dnc;
    always_comb begin
        c_rr   = sel ? req_ready1 : req_ready0;
        c_rdv  = sel ? rd_valid1  : rd_valid0;
        c_rdd  = sel ? rd_data1   : rd_data0;
        c_done = sel ? done1      : done0;
        c_err  = sel ? err1       : err0;
        c_vfc  = sel ? vf_cyc1    : vf_cyc0;
        c_dnc  = sel ? dn_cyc1    : dn_cyc0;
    end

    // Flash contents seen by the master model
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hA0A0_A0A3;
            32'h0000_1004: return 32'h5A5A_5A5A;
            32'h0000_1008: return 32'hDF00_0000;
            default:       return (a * 32'h9E37_79B1) ^ 32'h3C3C_0F0F;
        endcase
    endfunction

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [9:0]  fs;
    } iss_t;

    iss_t iss_q[$];
    int   mode = 0;       // 0 normal, 1 never answers, 2 answers very late
    bit   late_seen;

    // Flash master model: records each command and answers per mode
    initial begin
        iss_t it;
        tready = 1'b1; vfo = 1'b0; fdata = '0; act = 1'b0; late_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (fl0.validflag || fl1.validflag) begin
                act = fl1.validflag;
                it.cmd  = act ? fl1.command      : fl0.command;
                it.addr = act ? fl1.address      : fl0.address;
                it.fs   = act ? fl1.frame_struct : fl0.frame_struct;
                iss_q.push_back(it);
                tready = 1'b0;
                if (mode == 0) begin
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    fdata = mem_word(it.addr); vfo = 1'b1;
                    @(negedge clk);
                    vfo = 1'b0; fdata = $urandom;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end else if (mode == 1) begin
                    repeat (8) @(negedge clk);
                end else begin
                    repeat (20) @(negedge clk);
                    fdata = 32'hFFFF_FFFF; vfo = 1'b1; late_seen = 1'b1;
                    @(negedge clk);
                    vfo = 1'b0;
                end
                tready = 1'b1;
            end
        end
    end

    int unsigned n_total = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req_valid(input bit s, input logic v);
        if (s) req_valid1 = v; else req_valid0 = v;
    endtask

    // One block read on instance s, checked against the word-list model
    task automatic run_block(input bit s, input logic [31:0] a, input int unsigned n,
                             input bit q, input int unsigned stall);
        logic [31:0] ea[$];
        logic [7:0]  ecmd;
        logic [9:0]  efs;
        logic [31:0] held;
        bit          four, have_held;
        int unsigned vf0, dn0, got, guard, stall_cnt;
        four = (s == 1'b0);
        sel  = s;
        for (int unsigned i = 0; i < n; i++)
            ea.push_back(four ? (a & 32'hFFFF_FFFC) + 4 * i
                              : ((a & 32'h00FF_FFFC) + 4 * i) & 32'h00FF_FFFF);
        ecmd = q ? (four ? 8'h6C : 8'h6B) : (four ? 8'h0C : 8'h0B);
        efs  = q ? 10'h008 : 10'h000;
        mode = 0;
        guard = 0;
        while (tready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        iss_q.delete();
        chk("req_ready_idle", c_rr, 1);
        vf0 = c_vfc; dn0 = c_dnc;
        req_addr = a; req_nwords = n[7:0]; req_quad = q;
        set_req_valid(s, 1'b1);
        @(negedge clk);
        set_req_valid(s, 1'b0);
        if (n == 0) begin
            chk("zero_done", c_done, 1);
            chk("zero_req_ready", c_rr, 1);
            repeat (10) @(negedge clk);
            chk("zero_no_validflag", c_vfc - vf0, 0);
            chk("zero_done_once", c_dnc - dn0, 1);
            return;
        end
        chk("accept_err_clear", c_err, 0);
        chk("accept_busy", c_rr, 0);
        got = 0; guard = 0; have_held = 1'b0; stall_cnt = 0; rd_ready = 1'b0;
        while (got < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (have_held) begin
                chk("rd_valid_held", c_rdv, 1);
                chk("rd_data_stable", c_rdd, held);
            end
            have_held = 1'b0;
            if (c_rdv) begin
                if (stall != 0 && got == 0 && stall_cnt < stall) begin
                    rd_ready = 1'b0;
                    stall_cnt++;
                    set_req_valid(s, stall_cnt == 10);
                    if (stall_cnt == stall) chk("stall_single_issue", iss_q.size(), 1);
                end else begin
                    set_req_valid(s, 1'b0);
                    rd_ready = ($urandom_range(0, 3) != 0);
                end
                if (rd_ready) begin
                    chk("rd_data_word", c_rdd, mem_word(ea[got]));
                    got++;
                end else begin
                    held = c_rdd; have_held = 1'b1;
                end
            end else begin
                rd_ready = $urandom_range(0, 1);
            end
        end
        chk("words_received", got, n);
        @(negedge clk);
        rd_ready = 1'b0;
        chk("done_with_last", c_done, 1);
        chk("rd_valid_fell", c_rdv, 0);
        chk("req_ready_back", c_rr, 1);
        repeat (3) @(negedge clk);
        chk("done_once", c_dnc - dn0, 1);
        chk("validflag_cycles", c_vfc - vf0, n);
        chk("issue_count", iss_q.size(), n);
        chk("err_after_block", c_err, 0);
        for (int i = 0; i < int'(n) && i < iss_q.size(); i++) begin
            chk("issue_cmd", iss_q[i].cmd, ecmd);
            chk("issue_addr", iss_q[i].addr, ea[i]);
            chk("issue_fs", iss_q[i].fs, efs);
        end
    endtask

    initial begin
        int unsigned guard, t0, vbase;
        bit seen;
        rst = 1'b1; req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_addr = '0; req_nwords = '0; req_quad = 1'b0; rd_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_req_ready", req_ready0, 1);
        chk("rst_rd_valid", rd_valid0, 0);
        chk("rst_rd_data", rd_data0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_validflag", fl0.validflag, 0);
        chk("rst_command", fl0.command, 0);
        chk("rst_address", fl0.address, 0);
        chk("rst_frame_struct", fl0.frame_struct, 10'h000);
        chk("const_commtype", fl0.commtype, 3'b010);
        chk("const_ndata_bits", fl0.ndata_bits, 7'd32);
        chk("const_dummy", fl0.dummy_cycles, 4'd8);
        chk("const_4byte_on", fl0.fourbyteaddr_on, 1);
        chk("const_3byte_off", fl1.fourbyteaddr_on, 0);
        chk("const_misc", {fl0.xipbit_en, fl0.spimode, fl0.manualframe_en}, 0);
        chk("const_data_in", fl0.data_in, 0);
        rst = 1'b0;

        run_block(1'b0, 32'h0000_1003, 3, 1'b0, 0);
        run_block(1'b1, 32'h00FF_FFFC, 2, 1'b1, 0);
        run_block(1'b0, 32'h0000_2000, 2, 1'b0, 50);
        run_block(1'b0, 32'hFFFF_FFF8, 3, 1'b1, 0);
        run_block(1'b0, 32'h0000_0100, 0, 1'b0, 0);
        run_block(1'b1, 32'h0000_0200, 0, 1'b1, 0);

        // Timeout: master never answers
        sel = 1'b0; mode = 1;
        @(negedge clk);
        req_addr = 32'h0000_3000; req_nwords = 8'd2; req_quad = 1'b0; req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        guard = 0;
        while (!fl0.validflag && guard < 100) begin @(negedge clk); guard++; end
        chk("tmo_issue_seen", fl0.validflag, 1);
        t0 = cyc; seen = 1'b0; guard = 0;
        do begin
            @(negedge clk); guard++;
            if (rd_valid0) seen = 1'b1;
        end while (!done0 && guard < 200);
        chk("tmo_latency", cyc - t0, TO);
        chk("tmo_err", err0, 1);
        chk("tmo_req_ready", req_ready0, 1);
        chk("tmo_no_rd_valid", seen, 0);
        @(negedge clk);
        chk("tmo_err_sticky", err0, 1);
        chk("tmo_done_single", done0, 0);
        run_block(1'b0, 32'h0000_0040, 1, 1'b0, 0);

        // Reset during WAIT_DATA, master answers after reset is released
        sel = 1'b0; mode = 2;
        @(negedge clk);
        req_addr = 32'h0000_5000; req_nwords = 8'd2; req_quad = 1'b1; req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        guard = 0;
        while (!fl0.validflag && guard < 100) begin @(negedge clk); guard++; end
        chk("rstmid_issue_seen", fl0.validflag, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_validflag", fl0.validflag, 0);
        chk("rstmid_rd_valid", rd_valid0, 0);
        chk("rstmid_req_ready", req_ready0, 1);
        vbase = vf_cyc0; seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rd_valid0) seen = 1'b1;
        end
        chk("late_pulse_sent", late_seen, 1);
        chk("late_pulse_ignored", seen, 0);
        chk("rstmid_no_issue", vf_cyc0 - vbase, 0);

        // Randomized blocks on both instances
        for (int k = 0; k < 8; k++)
            run_block(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 5),
                      1'($urandom_range(0, 1)), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Last-resort bound on total run time
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
